// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state TMS FSM, IR, BYPASS, user DR port,
// and an optional IDCODE register enabled by defining JTAG_TAP_IDCODE_EN.
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH      = 4,
    parameter int          USER_DR_WIDTH = 16,
    parameter logic [31:0] IDCODE_VAL    = 32'h1000_0001,
    parameter logic [3:0]  IDCODE_OP     = 4'b0001,
    parameter logic [3:0]  USER_OP       = 4'b0010
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tms,
    input  logic                     tdi,
    output logic                     tdo,
    output logic                     tdo_en,
    output logic [3:0]               state,
    output logic [IR_WIDTH-1:0]      ir,
    output logic                     user_sel,
    output logic                     user_capture,
    output logic                     user_shift,
    output logic                     user_update,
    input  logic [USER_DR_WIDTH-1:0] user_cap_data,
    output logic [USER_DR_WIDTH-1:0] user_upd_data
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] USER_CODE  = IR_WIDTH'(USER_OP);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IDCODE_CODE = IR_WIDTH'(IDCODE_OP);
    localparam logic [IR_WIDTH-1:0] RESET_OP    = IDCODE_CODE;
`else
    localparam logic [IR_WIDTH-1:0] RESET_OP    = {IR_WIDTH{1'b1}};
`endif

    tap_state_t                 state_reg, state_next;
    logic [IR_WIDTH-1:0]        ir_reg, ir_shift_reg, ir_shifted;
    logic                       bypass_reg;
    logic [USER_DR_WIDTH-1:0]   user_shift_reg, user_upd_reg, user_shifted;
    logic                       tdo_reg, tdo_en_reg, dr_lsb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= TLR;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TLR:    state_next = tms ? TLR    : RTI;
            RTI:    state_next = tms ? SEL_DR : RTI;
            SEL_DR: state_next = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_next = tms ? EX1_DR : SH_DR;
            SH_DR:  state_next = tms ? EX1_DR : SH_DR;
            EX1_DR: state_next = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_next = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_next = tms ? UPD_DR : SH_DR;
            UPD_DR: state_next = tms ? SEL_DR : RTI;
            SEL_IR: state_next = tms ? TLR    : CAP_IR;
            CAP_IR: state_next = tms ? EX1_IR : SH_IR;
            SH_IR:  state_next = tms ? EX1_IR : SH_IR;
            EX1_IR: state_next = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_next = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_next = tms ? UPD_IR : SH_IR;
            UPD_IR: state_next = tms ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    // A 1-bit user register has no upper bits to slide down
    generate
        if (USER_DR_WIDTH == 1) begin : g_user_one
            assign user_shifted = tdi;
        end else begin : g_user_wide
            assign user_shifted = {tdi, user_shift_reg[USER_DR_WIDTH-1:1]};
        end
    endgenerate
    assign ir_shifted = {tdi, ir_shift_reg[IR_WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_reg       <= RESET_OP;
            ir_shift_reg <= '0;
        end else begin
            if (state_reg == CAP_IR)     ir_shift_reg <= IR_CAPTURE;
            else if (state_reg == SH_IR) ir_shift_reg <= ir_shifted;
            if (state_next == TLR)        ir_reg <= RESET_OP;
            else if (state_reg == UPD_IR) ir_reg <= ir_shift_reg;
        end
    end

    assign user_sel     = (ir_reg == USER_CODE);
    assign user_capture = user_sel && (state_reg == CAP_DR);
    assign user_shift   = user_sel && (state_reg == SH_DR);
    assign user_update  = user_sel && (state_reg == UPD_DR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bypass_reg     <= 1'b0;
            user_shift_reg <= '0;
            user_upd_reg   <= '0;
        end else begin
            if (state_reg == CAP_DR)     bypass_reg <= 1'b0;
            else if (state_reg == SH_DR) bypass_reg <= tdi;
            if (user_capture)    user_shift_reg <= user_cap_data;
            else if (user_shift) user_shift_reg <= user_shifted;
            if (user_update)     user_upd_reg   <= user_shift_reg;
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_shift_reg;
    logic        idcode_sel;
    assign idcode_sel = (ir_reg == IDCODE_CODE) && !user_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   idcode_shift_reg <= '0;
        else if (state_reg == CAP_DR) idcode_shift_reg <= IDCODE_VAL;
        else if (state_reg == SH_DR)  idcode_shift_reg <= {tdi, idcode_shift_reg[31:1]};
    end

    assign dr_lsb = user_sel ? user_shift_reg[0] : (idcode_sel ? idcode_shift_reg[0] : bypass_reg);
`else
    assign dr_lsb = user_sel ? user_shift_reg[0] : bypass_reg;
`endif

    // TDO changes on the falling edge so the far end samples it on the next rise
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            tdo_reg    <= 1'b0;
            tdo_en_reg <= 1'b0;
        end else begin
            tdo_en_reg <= (state_reg == SH_DR) || (state_reg == SH_IR);
            if (state_reg == SH_IR)      tdo_reg <= ir_shift_reg[0];
            else if (state_reg == SH_DR) tdo_reg <= dr_lsb;
            else                         tdo_reg <= 1'b0;
        end
    end

    assign tdo           = tdo_reg;
    assign tdo_en        = tdo_en_reg;
    assign state         = state_reg;
    assign ir            = ir_reg;
    assign user_upd_data = user_upd_reg;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: FSM navigation, IR/DR scans, bypass, reset.
// Expectations follow JTAG_TAP_IDCODE_EN when it is defined for the build.
module tb_jtag_tap_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tms = 1'b1;
    logic        tdi = 1'b0;
    logic        tdo, tdo_en;
    logic [3:0]  state;
    logic [3:0]  ir;
    logic        user_sel, user_capture, user_shift, user_update;
    logic [15:0] user_cap_data = '0;
    logic [15:0] user_upd_data;

    int vectors = 0;
    int miscompares = 0;
    int cap_cnt, shf_cnt, upd_cnt, en_bad;

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [3:0]  EXP_RESET_IR = 4'b0001;
    localparam logic [31:0] EXP_IDSCAN   = 32'h1000_0001;
`else
    localparam logic [3:0]  EXP_RESET_IR = 4'b1111;
    localparam logic [31:0] EXP_IDSCAN   = 32'hFFFF_FFFE;
`endif

    jtag_tap_ctrl dut (
        .clk(clk), .reset(reset), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .state(state), .ir(ir), .user_sel(user_sel), .user_capture(user_capture),
        .user_shift(user_shift), .user_update(user_update),
        .user_cap_data(user_cap_data), .user_upd_data(user_upd_data)
    );

    always #5 clk = ~clk;

    // One TCK: drive inputs, then settle just past the falling edge for sampling
    task automatic clock(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        @(posedge clk);
        @(negedge clk);
        #1;
        cap_cnt += int'(user_capture);
        shf_cnt += int'(user_shift);
        upd_cnt += int'(user_update);
    endtask

    task automatic do_reset();
        tms = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // From RTI: full DR scan, returns tdo bits LSB first, ends in RTI
    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        cap_cnt = 0; shf_cnt = 0; upd_cnt = 0; en_bad = 0;
        dout = '0;
        clock(1'b1, 1'b0);
        clock(1'b0, 1'b0);
        clock(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            if (tdo_en !== 1'b1) en_bad++;
            clock(i == n - 1, din[i]);
        end
        clock(1'b1, 1'b0);
        clock(1'b0, 1'b0);
    endtask

    task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout);
        en_bad = 0;
        dout = '0;
        clock(1'b1, 1'b0);
        clock(1'b1, 1'b0);
        clock(1'b0, 1'b0);
        clock(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dout[i] = tdo;
            if (tdo_en !== 1'b1) en_bad++;
            clock(i == 3, din[i]);
        end
        clock(1'b1, 1'b0);
        clock(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
        vectors++; if (ir !== EXP_RESET_IR) begin miscompares++; $display("FAIL reset_ir: got %b expected %b", ir, EXP_RESET_IR); end
        vectors++; if ({tdo, tdo_en, user_capture, user_shift, user_update} !== 5'b0) begin
            miscompares++; $display("FAIL reset_outs: got %b expected 00000", {tdo, tdo_en, user_capture, user_shift, user_update}); end
        vectors++; if (user_upd_data !== 16'h0) begin miscompares++; $display("FAIL reset_upd: got %h expected 0000", user_upd_data); end
    endtask

    task automatic test_idcode();
        logic [63:0] d;
        do_reset();
        clock(1'b0, 1'b0);
        scan_dr(32, {64{1'b1}}, d);
        vectors++; if (d[31:0] !== EXP_IDSCAN) begin miscompares++; $display("FAIL idcode_scan: got %h expected %h", d[31:0], EXP_IDSCAN); end
        vectors++; if (en_bad != 0) begin miscompares++; $display("FAIL idcode_tdo_en: got %0d low cycles expected 0", en_bad); end
        vectors++; if (state !== 4'd1) begin miscompares++; $display("FAIL idcode_end_state: got %0d expected 1", state); end
    endtask

    task automatic tlr5(input string name);
        for (int i = 0; i < 5; i++) clock(1'b1, 1'b0);
        vectors++; if (state !== 4'd0) begin miscompares++; $display("FAIL tlr5_%s: got state %0d expected 0", name, state); end
        vectors++; if (ir !== EXP_RESET_IR) begin miscompares++; $display("FAIL tlr5_ir_%s: got %b expected %b", name, ir, EXP_RESET_IR); end
    endtask

    task automatic test_tlr_five();
        do_reset();
        clock(1'b0, 1'b0);
        vectors++; if (state !== 4'd1) begin miscompares++; $display("FAIL nav_rti: got %0d expected 1", state); end
        tlr5("rti");
        clock(1'b0, 1'b0); clock(1'b1, 1'b0); clock(1'b1, 1'b0); clock(1'b0, 1'b0);
        clock(1'b0, 1'b0); clock(1'b1, 1'b0); clock(1'b0, 1'b0);
        vectors++; if (state !== 4'd13) begin miscompares++; $display("FAIL nav_pau_ir: got %0d expected 13", state); end
        tlr5("pau_ir");
        clock(1'b0, 1'b0); clock(1'b1, 1'b0); clock(1'b0, 1'b0); clock(1'b0, 1'b0);
        vectors++; if (state !== 4'd4) begin miscompares++; $display("FAIL nav_sh_dr: got %0d expected 4", state); end
        tlr5("sh_dr");
        clock(1'b0, 1'b0); clock(1'b1, 1'b0); clock(1'b1, 1'b0); clock(1'b0, 1'b0);
        clock(1'b1, 1'b0); clock(1'b1, 1'b0);
        vectors++; if (state !== 4'd15) begin miscompares++; $display("FAIL nav_upd_ir: got %0d expected 15", state); end
        tlr5("upd_ir");
    endtask

    task automatic test_ir_scan();
        logic [3:0] d;
        do_reset();
        clock(1'b0, 1'b0);
        scan_ir(4'b0010, d);
        vectors++; if (d !== 4'b0001) begin miscompares++; $display("FAIL ir_capture: got %b expected 0001", d); end
        vectors++; if (ir !== 4'b0010) begin miscompares++; $display("FAIL ir_update: got %b expected 0010", ir); end
        vectors++; if (user_sel !== 1'b1) begin miscompares++; $display("FAIL ir_user_sel: got %b expected 1", user_sel); end
        vectors++; if (en_bad != 0) begin miscompares++; $display("FAIL ir_tdo_en: got %0d low cycles expected 0", en_bad); end
    endtask

    task automatic test_user_dr();
        logic [63:0] d;
        user_cap_data = 16'hA5C3;
        scan_dr(16, 64'h1234, d);
        vectors++; if (d[15:0] !== 16'hA5C3) begin miscompares++; $display("FAIL user_tdo: got %h expected a5c3", d[15:0]); end
        vectors++; if (cap_cnt != 1) begin miscompares++; $display("FAIL user_capture: got %0d pulses expected 1", cap_cnt); end
        vectors++; if (upd_cnt != 1) begin miscompares++; $display("FAIL user_update: got %0d pulses expected 1", upd_cnt); end
        vectors++; if (shf_cnt != 16) begin miscompares++; $display("FAIL user_shift: got %0d cycles expected 16", shf_cnt); end
        vectors++; if (user_upd_data !== 16'h1234) begin miscompares++; $display("FAIL user_upd: got %h expected 1234", user_upd_data); end
        tlr5("from_user");
        vectors++; if (user_upd_data !== 16'h1234) begin miscompares++; $display("FAIL tlr_keeps_upd: got %h expected 1234", user_upd_data); end
        vectors++; if (user_sel !== 1'b0) begin miscompares++; $display("FAIL tlr_user_sel: got %b expected 0", user_sel); end
    endtask

    task automatic test_bypass();
        logic [3:0] d;
        logic [3:0] got;
        do_reset();
        clock(1'b0, 1'b0);
        scan_ir(4'b1111, d);
        vectors++; if (ir !== 4'b1111) begin miscompares++; $display("FAIL bypass_ir: got %b expected 1111", ir); end
        clock(1'b1, 1'b0); clock(1'b0, 1'b0); clock(1'b0, 1'b0);
        got[0] = tdo; clock(1'b0, 1'b1);
        got[1] = tdo; clock(1'b0, 1'b0);
        got[2] = tdo; clock(1'b1, 1'b1);
        clock(1'b0, 1'b0); clock(1'b0, 1'b0);
        vectors++; if ({state, tdo, tdo_en} !== {4'd6, 2'b00}) begin
            miscompares++; $display("FAIL bypass_pause: got state %0d tdo %b en %b expected 6 0 0", state, tdo, tdo_en); end
        clock(1'b1, 1'b0); clock(1'b0, 1'b0);
        got[3] = tdo; clock(1'b0, 1'b1);
        vectors++; if (got !== 4'b1010) begin miscompares++; $display("FAIL bypass_delay: got %b expected 1010 (lsb first 0,1,0,1)", got); end
        vectors++; if (tdo !== 1'b1) begin miscompares++; $display("FAIL bypass_last: got %b expected 1", tdo); end
        clock(1'b1, 1'b0); clock(1'b1, 1'b0); clock(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [3:0]  d;
        logic [63:0] q;
        scan_ir(4'b0010, d);
        user_cap_data = 16'h0F0F;
        scan_dr(16, 64'hBEEF, q);
        vectors++; if (q[15:0] !== 16'h0F0F) begin miscompares++; $display("FAIL b2b_first_tdo: got %h expected 0f0f", q[15:0]); end
        vectors++; if (user_upd_data !== 16'hBEEF) begin miscompares++; $display("FAIL b2b_first_upd: got %h expected beef", user_upd_data); end
        user_cap_data = 16'h8001;
        scan_dr(16, 64'h00FF, q);
        vectors++; if (q[15:0] !== 16'h8001) begin miscompares++; $display("FAIL b2b_second_tdo: got %h expected 8001", q[15:0]); end
        vectors++; if (user_upd_data !== 16'h00FF) begin miscompares++; $display("FAIL b2b_second_upd: got %h expected 00ff", user_upd_data); end
    endtask

    task automatic test_async_reset();
        clock(1'b1, 1'b0); clock(1'b0, 1'b0); clock(1'b0, 1'b0);
        vectors++; if ({state, tdo_en} !== {4'd4, 1'b1}) begin
            miscompares++; $display("FAIL pre_async: got state %0d en %b expected 4 1", state, tdo_en); end
        tms = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        vectors++; if ({state, tdo, tdo_en} !== {4'd0, 2'b00}) begin
            miscompares++; $display("FAIL async_state: got state %0d tdo %b en %b expected 0 0 0", state, tdo, tdo_en); end
        vectors++; if (ir !== EXP_RESET_IR) begin miscompares++; $display("FAIL async_ir: got %b expected %b", ir, EXP_RESET_IR); end
        vectors++; if (user_upd_data !== 16'h0) begin miscompares++; $display("FAIL async_upd: got %h expected 0000", user_upd_data); end
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_tlr_five();
        test_ir_scan();
        test_user_dr();
        test_bypass();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
